// File: rtl/peak_detector.sv
// Pulse peak detector: tracks amplitude and timestamp of the maximum of each over-threshold pulse.
// Optional feature: define PEAK_TIMESTAMP_EN to keep the timestamp counter; otherwise peak_time reads 0.

package package_settings;
    localparam int SIZE_FILTER_DATA = 16;
endpackage

module peak_detector
    import package_settings::*;
#(
    parameter int HOLDOFF_LEN = 16,
    parameter int MAX_WIDTH   = 64,
    parameter int TIME_W      = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    input  logic                               out_ready,
    output logic                               peak_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
    output logic        [TIME_W-1:0]           peak_time,
    output logic                               pileup,
    output logic        [7:0]                  drop_cnt,
    output logic                               busy
);

    localparam int WIDTH_W = $clog2(MAX_WIDTH + 1);
    localparam int HOLD_W  = (HOLDOFF_LEN > 1) ? $clog2(HOLDOFF_LEN) : 1;
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = WIDTH_W'(MAX_WIDTH);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLDOFF_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ABOVE,
        OVERLONG,
        HOLDOFF
    } state_t;

    state_t                             state;
    logic        [WIDTH_W-1:0]          width;
    logic        [HOLD_W-1:0]           hold_cnt;
    logic signed [SIZE_FILTER_DATA-1:0] max_val;

    logic over;
    logic emit;
    logic emit_pileup;
    logic accept;

`ifdef PEAK_TIMESTAMP_EN
    logic [TIME_W-1:0] time_cnt;
    logic [TIME_W-1:0] max_time;
    logic [TIME_W-1:0] peak_time_q;

    always_ff @(posedge clk) begin
        if (!reset) time_cnt <= '0;
        else        time_cnt <= time_cnt + TIME_W'(1);
    end

    assign peak_time = peak_time_q;
`else
    assign peak_time = '0;
`endif

    // Signed compare: both operands are declared signed.
    assign over = (input_data > threshold);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        emit        = 1'b0;
        emit_pileup = 1'b0;
        if (state == ABOVE) begin
            if (!over) begin
                emit = 1'b1;
            end else if (width == WIDTH_MAX) begin
                emit        = 1'b1;
                emit_pileup = 1'b1;
            end
        end
    end

    // A result only lands in the output register if the slot is free or being drained this cycle.
    assign accept = emit && (!peak_valid || out_ready);
    assign busy   = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            width          <= '0;
            hold_cnt       <= '0;
            max_val        <= '0;
            peak_valid     <= 1'b0;
            peak_amplitude <= '0;
            pileup         <= 1'b0;
            drop_cnt       <= '0;
`ifdef PEAK_TIMESTAMP_EN
            max_time       <= '0;
            peak_time_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (over) begin
                        state   <= ABOVE;
                        max_val <= input_data;
                        width   <= WIDTH_W'(1);
`ifdef PEAK_TIMESTAMP_EN
                        max_time <= time_cnt;
`endif
                    end
                end
                ABOVE: begin
                    if (!over) begin
                        state    <= HOLDOFF;
                        hold_cnt <= '0;
                    end else if (width == WIDTH_MAX) begin
                        state <= OVERLONG;
                    end else begin
                        width <= width + WIDTH_W'(1);
                        // Strictly greater: a repeated maximum keeps the earlier timestamp.
                        if (input_data > max_val) begin
                            max_val <= input_data;
`ifdef PEAK_TIMESTAMP_EN
                            max_time <= time_cnt;
`endif
                        end
                    end
                end
                OVERLONG: begin
                    if (!over) begin
                        state    <= HOLDOFF;
                        hold_cnt <= '0;
                    end
                end
                HOLDOFF: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                peak_valid     <= 1'b1;
                peak_amplitude <= max_val;
                pileup         <= emit_pileup;
`ifdef PEAK_TIMESTAMP_EN
                peak_time_q    <= max_time;
`endif
            end else if (emit) begin
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end else if (peak_valid && out_ready) begin
                peak_valid <= 1'b0;
            end
        end
    end

endmodule
